branch_resolve_unit: RTL

- EX-side counterpart to the BTB lookup path.
- Carries each fetched PC's BTB prediction through IF->ID->EX and compares it against the actual branch outcome in EX.
- Produces the BTB write-back (allocate or invalidate), the front-end redirect PC, and the pipeline kill.
- Owns a small flush FSM that suppresses wrong-path work until the redirect takes effect.

---
 rtl/branch_resolve_unit_pkg.sv | 20 ++
 rtl/bru_pred_pipe.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit.
// Widths match the BTB lookup path; FSM encoding RUN=0, FLUSH=1.
package branch_resolve_unit_pkg;

    localparam int PC_WIDTH_DEF      = 32;
    localparam int BTB_IDX_WIDTH_DEF = 6;

    typedef struct packed {
        logic                    valid;
        logic [PC_WIDTH_DEF-1:0] pc;
        logic                    pred_taken;
        logic [PC_WIDTH_DEF-1:0] pred_target;
    } pred_slot_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_t;

endpackage

// File: rtl/bru_pred_pipe.sv
// Two-slot (ID, EX) prediction pipeline.
// Slots advance when not stalled; kill drops both slots' valid bits.
module bru_pred_pipe
    import branch_resolve_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       kill,
    input  pred_slot_t if_slot,
    output pred_slot_t ex_slot
);

    pred_slot_t id_q, id_d;
    pred_slot_t ex_q, ex_d;

    // Shift IF->ID->EX unless held; a kill empties both slots.
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (!stall) begin
            id_d = if_slot;
            ex_d = id_q;
        end
        if (kill) begin
            id_d.valid = 1'b0;
            ex_d.valid = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign ex_slot = ex_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BTB predictions in EX: BTB write-back, redirect, flush FSM.
// Optional perf counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_WIDTH      = PC_WIDTH_DEF,
    parameter int BTB_IDX_WIDTH = BTB_IDX_WIDTH_DEF,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     if_valid,
    input  logic [PC_WIDTH-1:0]      if_pc,
    input  logic                     if_pred_taken,
    input  logic [PC_WIDTH-1:0]      if_pred_target,
    input  logic                     ex_is_branch,
    input  logic                     ex_actual_taken,
    input  logic [PC_WIDTH-1:0]      ex_actual_target,
    output logic                     btb_upd_en,
    output logic [BTB_IDX_WIDTH-1:0] btb_upd_tag,
    output logic [PC_WIDTH-1:0]      btb_upd_target,
    output logic                     btb_upd_valid,
    output logic                     redirect_valid,
    output logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     flush,
    output logic [PC_WIDTH-1:0]      ex_slot_pc
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]              perf_branches,
    output logic [31:0]              perf_mispredicts,
    output logic [31:0]              perf_aliases
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    bru_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    pred_slot_t if_slot;
    pred_slot_t ex_slot;

    logic                eval;
    logic                act_taken;
    logic                mispredict;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] fix_pc;

    logic                     redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0]      redirect_pc_q, redirect_pc_d;
    logic                     btb_upd_en_q, btb_upd_en_d;
    logic [BTB_IDX_WIDTH-1:0] btb_upd_tag_q, btb_upd_tag_d;
    logic [PC_WIDTH-1:0]      btb_upd_target_q, btb_upd_target_d;
    logic                     btb_upd_valid_q, btb_upd_valid_d;

    // Fetch capture; wrong-path fetches during FLUSH enter as bubbles.
    always_comb begin
        if_slot             = '0;
        if_slot.valid       = if_valid && (state_q == ST_RUN);
        if_slot.pc          = if_pc;
        if_slot.pred_taken  = if_pred_taken;
        if_slot.pred_target = if_pred_target;
    end

    bru_pred_pipe u_pipe (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .kill    (mispredict),
        .if_slot (if_slot),
        .ex_slot (ex_slot)
    );

    // Compare the carried prediction against the resolved outcome.
    always_comb begin
        eval       = (state_q == ST_RUN) && !stall && ex_slot.valid;
        act_taken  = ex_is_branch && ex_actual_taken;
        seq_pc     = ex_slot.pc + PC_WIDTH'(4);
        fix_pc     = seq_pc;
        mispredict = ex_slot.pred_taken;
        if (act_taken) begin
            fix_pc     = ex_actual_target;
            mispredict = !ex_slot.pred_taken
                      || (ex_slot.pred_target != ex_actual_target);
        end
        mispredict = mispredict && eval;
    end

    // Single-cycle redirect and BTB write pulses.
    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = mispredict ? fix_pc : '0;
        btb_upd_en_d     = mispredict;
        btb_upd_tag_d    = '0;
        btb_upd_target_d = '0;
        btb_upd_valid_d  = mispredict && act_taken;
        if (mispredict) begin
            btb_upd_tag_d    = ex_slot.pc[BTB_IDX_WIDTH+1:2];
            btb_upd_target_d = ex_actual_target;
        end
    end

    // Flush FSM next state; stall freezes it while flushing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            btb_upd_en_q     <= 1'b0;
            btb_upd_tag_q    <= '0;
            btb_upd_target_q <= '0;
            btb_upd_valid_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            btb_upd_en_q     <= btb_upd_en_d;
            btb_upd_tag_q    <= btb_upd_tag_d;
            btb_upd_target_q <= btb_upd_target_d;
            btb_upd_valid_q  <= btb_upd_valid_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign btb_upd_en     = btb_upd_en_q;
    assign btb_upd_tag    = btb_upd_tag_q;
    assign btb_upd_target = btb_upd_target_q;
    assign btb_upd_valid  = btb_upd_valid_q;
    assign flush          = (state_q == ST_FLUSH);
    assign ex_slot_pc     = ex_slot.pc;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;
    logic [31:0] al_cnt_q, al_cnt_d;

    // Saturating event counters.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        al_cnt_d = al_cnt_q;
        if (eval && ex_is_branch && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + 32'd1;
        end
        if (mispredict && !ex_is_branch && (al_cnt_q != '1)) begin
            al_cnt_d = al_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
            al_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
            al_cnt_q <= al_cnt_d;
        end
    end

    assign perf_branches    = br_cnt_q;
    assign perf_mispredicts = mp_cnt_q;
    assign perf_aliases     = al_cnt_q;
`endif

endmodule
